// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back path: datapath widths, functional-unit
// identifiers and the hard-wired zero register index.
package wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_W  = 5;
    localparam int FU_ID_W   = 3;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [FU_ID_W-1:0] {
        FU_ALU = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_MEM = 3'd3
    } fu_id_e;

endpackage

// File: rtl/wb_fifo.sv
// Single-FU result FIFO: registered count and pointers, head visible combinationally.
// Push and pop are guarded internally so a stray request never corrupts state.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push,  do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a value unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the count
    // guarantees stale entries are never observed, and unreset RAM maps cleanly.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: buffers FU results per unit, picks one per cycle round-robin,
// and registers the register-file write port plus the retire report.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_W  = WB_REG_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*REG_W-1:0]  fu_dest,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     wb_enable,
    output logic [REG_W-1:0]         wb_dest,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     wb_retire,
    output logic [FU_ID_W-1:0]       wb_fu_id
);

    localparam int PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int ENTRY_W = REG_W + DATA_W;

    logic [NUM_FU-1:0]  fifo_push;
    logic [NUM_FU-1:0]  fifo_pop;
    logic [NUM_FU-1:0]  fifo_full;
    logic [NUM_FU-1:0]  fifo_empty;
    logic [ENTRY_W-1:0] fifo_head [NUM_FU];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [REG_W-1:0]   grant_dest;
    logic [DATA_W-1:0]  grant_data;
    int                 scan_idx;

    logic               wb_enable_q, wb_enable_d;
    logic               wb_retire_q, wb_retire_d;
    logic [REG_W-1:0]   wb_dest_q,   wb_dest_d;
    logic [DATA_W-1:0]  wb_data_q,   wb_data_d;
    logic [FU_ID_W-1:0] wb_fu_id_q,  wb_fu_id_d;

    // Ready depends only on the registered count: a full FIFO stays not-ready
    // even in a cycle where it is being popped.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        assign fu_ready[i]  = !fifo_full[i];
        assign fifo_push[i] = fu_valid[i] && !fifo_full[i];

        wb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .push_i  (fifo_push[i]),
            .wdata_i ({fu_dest[i*REG_W +: REG_W], fu_data[i*DATA_W +: DATA_W]}),
            .pop_i   (fifo_pop[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i]),
            .head_o  (fifo_head[i])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!grant_valid && !fifo_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (grant_valid) begin
            fifo_pop[grant_idx] = 1'b1;
        end
    end

    assign {grant_dest, grant_data} = fifo_head[grant_idx];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Dest 0 still retires so the scoreboard clears the entry, but never writes.
    always_comb begin
        wb_retire_d = grant_valid;
        wb_enable_d = grant_valid && (grant_dest != REG_W'(REG_ZERO));
        wb_dest_d   = wb_dest_q;
        wb_data_d   = wb_data_q;
        wb_fu_id_d  = wb_fu_id_q;
        if (grant_valid) begin
            wb_dest_d  = grant_dest;
            wb_data_d  = grant_data;
            wb_fu_id_d = FU_ID_W'(grant_idx);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            wb_enable_q <= 1'b0;
            wb_retire_q <= 1'b0;
            wb_dest_q   <= '0;
            wb_data_q   <= '0;
            wb_fu_id_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wb_enable_q <= wb_enable_d;
            wb_retire_q <= wb_retire_d;
            wb_dest_q   <= wb_dest_d;
            wb_data_q   <= wb_data_d;
            wb_fu_id_q  <= wb_fu_id_d;
        end
    end

    assign wb_enable = wb_enable_q;
    assign wb_retire = wb_retire_q;
    assign wb_dest   = wb_dest_q;
    assign wb_data   = wb_data_q;
    assign wb_fu_id  = wb_fu_id_q;

    a_pop_onehot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(fifo_pop) && ((fifo_pop & fifo_empty) == '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, backpressure,
// zero-register retire, mid-run reset and same-cycle push/pop.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*REG_W-1:0]  fu_dest;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     wb_enable;
    logic [REG_W-1:0]         wb_dest;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_retire;
    logic [2:0]               wb_fu_id;

    logic [REG_W-1:0]  dest_a [NUM_FU];
    logic [DATA_W-1:0] data_a [NUM_FU];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_pack
        assign fu_dest[i*REG_W +: REG_W]   = dest_a[i];
        assign fu_data[i*DATA_W +: DATA_W] = data_a[i];
    end

    always #5 clock = ~clock;

    wb_arbiter #(
        .NUM_FU (NUM_FU),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fu_valid  (fu_valid),
        .fu_dest   (fu_dest),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .wb_enable (wb_enable),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .wb_retire (wb_retire),
        .wb_fu_id  (wb_fu_id)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input logic [1:0] fu, input logic [4:0] d, input logic [31:0] v);
        fu_valid[fu] = 1'b1;
        dest_a[fu]   = d;
        data_a[fu]   = v;
    endtask

    task automatic clr_fu(input logic [1:0] fu);
        fu_valid[fu] = 1'b0;
    endtask

    task automatic expect_wb(input string tag, input logic [1:0] fu, input logic [4:0] d,
                             input logic [31:0] v, input logic en);
        check({tag, "/retire"}, 64'(wb_retire), 64'(1'b1));
        check({tag, "/fu_id"},  64'(wb_fu_id),  64'(fu));
        check({tag, "/dest"},   64'(wb_dest),   64'(d));
        check({tag, "/data"},   64'(wb_data),   64'(v));
        check({tag, "/enable"}, 64'(wb_enable), 64'(en));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "/retire"}, 64'(wb_retire), 64'(1'b0));
        check({tag, "/enable"}, 64'(wb_enable), 64'(1'b0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Backpressure scenario: expected retire order worked out by hand.
    logic [1:0] exp_fu [8] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    int         exp_k  [8] = '{0, 0, 1, 1, 2, 2, 3, 4};

    initial begin
        int  idx0;
        int  idx2;
        bit  acc0;
        bit  acc2;
        logic [1:0] efu;
        int  ek;

        reset    = 1'b0;
        fu_valid = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            dest_a[i] = '0;
            data_a[i] = '0;
        end

        // Reset state
        tick();
        check("rst/enable", 64'(wb_enable), 64'(1'b0));
        check("rst/retire", 64'(wb_retire), 64'(1'b0));
        check("rst/dest",   64'(wb_dest),   64'(5'd0));
        check("rst/data",   64'(wb_data),   64'(32'd0));
        check("rst/fu_id",  64'(wb_fu_id),  64'(3'd0));
        do_reset();
        check("rst/ready", 64'(fu_ready), 64'(4'b1111));
        expect_idle("rst/idle");

        // 1: single result, two-cycle latency
        set_fu(2'(FU_MUL), 5'd8, 32'h0000_00AA);
        tick();
        clr_fu(2'(FU_MUL));
        expect_idle("t1/early");
        tick();
        expect_wb("t1/wb", 2'(FU_MUL), 5'd8, 32'h0000_00AA, 1'b1);
        tick();
        expect_idle("t1/after");

        // 4: zero register retires without a write
        set_fu(2'(FU_MEM), 5'd0, 32'hDEAD_BEEF);
        tick();
        clr_fu(2'(FU_MEM));
        tick();
        expect_wb("t4/wb", 2'(FU_MEM), 5'd0, 32'hDEAD_BEEF, 1'b0);
        tick();
        expect_idle("t4/after");

        // 6: push and pop on the same FIFO in one cycle
        set_fu(2'(FU_ALU), 5'd14, 32'h30);
        tick();
        set_fu(2'(FU_ALU), 5'd15, 32'h31);
        check("t6/ready_pre", 64'(fu_ready[0]), 64'(1'b1));
        tick();
        clr_fu(2'(FU_ALU));
        expect_wb("t6/first", 2'(FU_ALU), 5'd14, 32'h30, 1'b1);
        check("t6/ready_mid", 64'(fu_ready[0]), 64'(1'b1));
        tick();
        expect_wb("t6/second", 2'(FU_ALU), 5'd15, 32'h31, 1'b1);
        tick();
        expect_idle("t6/after");

        // 2: round-robin fairness from rr_ptr = 0
        do_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(2'(i), 5'(8 + i), 32'(32'h10 + i));
        end
        tick();
        fu_valid = '0;
        expect_idle("t2/early");
        for (int i = 0; i < NUM_FU; i++) begin
            tick();
            expect_wb($sformatf("t2/rr%0d", i), 2'(i), 5'(8 + i), 32'(32'h10 + i), 1'b1);
        end
        tick();
        expect_idle("t2/after");
        // Pointer is back at 0: FU0 must beat FU3
        set_fu(2'(FU_MEM), 5'd12, 32'h20);
        set_fu(2'(FU_ALU), 5'd13, 32'h21);
        tick();
        fu_valid = '0;
        tick();
        expect_wb("t2/wrap0", 2'(FU_ALU), 5'd13, 32'h21, 1'b1);
        tick();
        expect_wb("t2/wrap3", 2'(FU_MEM), 5'd12, 32'h20, 1'b1);

        // 3: FU2 backpressure against a continuous FU0 stream
        do_reset();
        idx0 = 0;
        idx2 = 0;
        for (int n = 1; n <= 10; n++) begin
            if (idx0 < 5) set_fu(2'd0, 5'(16 + idx0), 32'(32'h100 + idx0));
            else          clr_fu(2'd0);
            if (idx2 < 3) set_fu(2'(FU_DIV), 5'(20 + idx2), 32'(32'h200 + idx2));
            else          clr_fu(2'(FU_DIV));
            acc0 = fu_valid[0] && fu_ready[0];
            acc2 = fu_valid[2] && fu_ready[2];
            tick();
            if (acc0) idx0++;
            if (acc2) idx2++;
            if (n == 1 || n == 10) begin
                expect_idle($sformatf("t3/idle%0d", n));
            end else begin
                efu = exp_fu[n-2];
                ek  = exp_k[n-2];
                if (efu == 2'd0)
                    expect_wb($sformatf("t3/e%0d", n), efu, 5'(16 + ek), 32'(32'h100 + ek), 1'b1);
                else
                    expect_wb($sformatf("t3/e%0d", n), efu, 5'(20 + ek), 32'(32'h200 + ek), 1'b1);
            end
            if (n == 2) check("t3/ready2_full", 64'(fu_ready[2]), 64'(1'b0));
            if (n == 3) check("t3/ready2_free", 64'(fu_ready[2]), 64'(1'b1));
        end
        fu_valid = '0;
        check("t3/fu0_accepted", 64'(idx0), 64'(5));
        check("t3/fu2_accepted", 64'(idx2), 64'(3));

        // 5: reset mid-operation discards buffered results
        set_fu(2'd0, 5'd1, 32'h40);
        set_fu(2'd1, 5'd2, 32'h41);
        tick();
        set_fu(2'd0, 5'd3, 32'h42);
        set_fu(2'd1, 5'd4, 32'h43);
        tick();
        fu_valid = '0;
        reset    = 1'b0;
        tick();
        check("t5/enable", 64'(wb_enable), 64'(1'b0));
        check("t5/retire", 64'(wb_retire), 64'(1'b0));
        check("t5/dest",   64'(wb_dest),   64'(5'd0));
        check("t5/data",   64'(wb_data),   64'(32'd0));
        check("t5/fu_id",  64'(wb_fu_id),  64'(3'd0));
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_idle($sformatf("t5/post%0d", i));
            check($sformatf("t5/ready%0d", i), 64'(fu_ready), 64'(4'b1111));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
